// File: rtl/machine_timer_if.sv
// Bus-matrix side of the machine timer: decoded active-low write strobes and
// write data in, the four register read values and the timer interrupt out.
interface machine_timer_if;
  logic [31:0] data_i;
  logic        wrtimel_n;
  logic        wrtimeh_n;
  logic        wrtimecmpl_n;
  logic        wrtimecmph_n;
  logic [31:0] mtimerl_o;
  logic [31:0] mtimerh_o;
  logic [31:0] mtimecmpl_o;
  logic [31:0] mtimecmph_o;
  logic        timer_int;

  modport master (
    output data_i, wrtimel_n, wrtimeh_n, wrtimecmpl_n, wrtimecmph_n,
    input  mtimerl_o, mtimerh_o, mtimecmpl_o, mtimecmph_o, timer_int
  );

  modport slave (
    input  data_i, wrtimel_n, wrtimeh_n, wrtimecmpl_n, wrtimecmph_n,
    output mtimerl_o, mtimerh_o, mtimecmpl_o, mtimecmph_o, timer_int
  );
endinterface

// File: rtl/machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) with registered level interrupt.
// Optional prescaler is built when MTIMER_PRESCALE_EN is defined.
module machine_timer #(
  parameter int unsigned PRESCALE = 16
) (
  input logic           clk,
  input logic           rst_n,
  machine_timer_if.slave bus
);

  if (PRESCALE < 2 || PRESCALE > 65536) begin : g_bad_prescale
    $error("machine_timer: PRESCALE must be within 2..65536");
  end

  logic [63:0] mtime;
  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp;
  logic [63:0] mtimecmp_nxt;
  logic        timer_int_q;
  logic        mtime_wr;
  logic        tick;

  // Any mtime write suppresses the increment and restarts the prescaler.
  assign mtime_wr = ~bus.wrtimel_n | ~bus.wrtimeh_n;

`ifdef MTIMER_PRESCALE_EN
  localparam int unsigned    CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] presc;
  logic [CW-1:0] presc_nxt;

  always_comb begin
    presc_nxt = presc + CW'(1);
    tick      = 1'b0;
    if (mtime_wr) begin
      presc_nxt = '0;
    end else if (presc == LAST) begin
      presc_nxt = '0;
      tick      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else begin
      presc <= presc_nxt;
    end
  end
`else
  assign tick = ~mtime_wr;
`endif

  always_comb begin
    mtime_nxt = mtime;
    if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
    if (!bus.wrtimel_n) begin
      mtime_nxt[31:0] = bus.data_i;
    end
    if (!bus.wrtimeh_n) begin
      mtime_nxt[63:32] = bus.data_i;
    end
  end

  always_comb begin
    mtimecmp_nxt = mtimecmp;
    if (!bus.wrtimecmpl_n) begin
      mtimecmp_nxt[31:0] = bus.data_i;
    end
    if (!bus.wrtimecmph_n) begin
      mtimecmp_nxt[63:32] = bus.data_i;
    end
  end

  // The interrupt samples the pre-edge register values, so it lags by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      timer_int_q <= 1'b0;
    end else begin
      mtime       <= mtime_nxt;
      mtimecmp    <= mtimecmp_nxt;
      timer_int_q <= (mtime >= mtimecmp);
    end
  end

  assign bus.mtimerl_o   = mtime[31:0];
  assign bus.mtimerh_o   = mtime[63:32];
  assign bus.mtimecmpl_o = mtimecmp[31:0];
  assign bus.mtimecmph_o = mtimecmp[63:32];
  assign bus.timer_int   = timer_int_q;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer (default build, no prescaler): reset/count,
// a vector table covering carry, wrap, compare, write priority and multi-strobe
// writes, and an asynchronous reset pulse in the middle of a run.
module tb_machine_timer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  machine_timer_if bus ();

  machine_timer #(.PRESCALE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wr;   // {mtime lo, mtime hi, cmp lo, cmp hi}, 1 = strobe low
    logic [31:0] data;
    logic [31:0] rl;
    logic [31:0] rh;
    logic [31:0] cl;
    logic [31:0] ch;
    logic        ti;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] rl, input logic [31:0] rh,
                           input logic [31:0] cl, input logic [31:0] ch, input logic ti);
    check({tag, " mtimerl"},   bus.mtimerl_o,   rl);
    check({tag, " mtimerh"},   bus.mtimerh_o,   rh);
    check({tag, " mtimecmpl"}, bus.mtimecmpl_o, cl);
    check({tag, " mtimecmph"}, bus.mtimecmph_o, ch);
    check({tag, " timer_int"}, {31'd0, bus.timer_int}, {31'd0, ti});
  endtask

  task automatic set_strobes(input logic [3:0] wr, input logic [31:0] data);
    bus.wrtimel_n    = ~wr[3];
    bus.wrtimeh_n    = ~wr[2];
    bus.wrtimecmpl_n = ~wr[1];
    bus.wrtimecmph_n = ~wr[0];
    bus.data_i       = data;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // State entering the table: mtime = 10, mtimecmp = all ones, timer_int = 0.
    vecs[0]  = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{4'b0100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{4'b0000, 32'h0,         32'h0,         32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{4'b0100, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{4'b0000, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{4'b0000, 32'h0,         32'h1,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{4'b1100, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{4'b0001, 32'h0,         32'h1,         32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[9]  = '{4'b0010, 32'h5,         32'h2,         32'h0,         32'h5,         32'h0,         1'b0};
    vecs[10] = '{4'b0000, 32'h0,         32'h3,         32'h0,         32'h5,         32'h0,         1'b0};
    vecs[11] = '{4'b0000, 32'h0,         32'h4,         32'h0,         32'h5,         32'h0,         1'b0};
    vecs[12] = '{4'b0000, 32'h0,         32'h5,         32'h0,         32'h5,         32'h0,         1'b0};
    vecs[13] = '{4'b0000, 32'h0,         32'h6,         32'h0,         32'h5,         32'h0,         1'b1};
    vecs[14] = '{4'b0010, 32'hFFFF_FFFF, 32'h7,         32'h0,         32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[15] = '{4'b0000, 32'h0,         32'h8,         32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[16] = '{4'b1000, 32'h100,       32'h100,       32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[17] = '{4'b1000, 32'h100,       32'h100,       32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[18] = '{4'b1000, 32'h100,       32'h100,       32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[19] = '{4'b0000, 32'h0,         32'h101,       32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[20] = '{4'b1111, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    vecs[21] = '{4'b0000, 32'h0,         32'hA5A5_A5A6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1};
    vecs[22] = '{4'b0000, 32'h0,         32'hA5A5_A5A7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1};

    set_strobes(4'b0000, 32'h0);

    // Reset values, then free-running count.
    #1 rst_n = 1'b0;
    #2 check_all("reset", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("count%0d mtimerl", i), bus.mtimerl_o, 32'(i + 1));
      check($sformatf("count%0d timer_int", i), {31'd0, bus.timer_int}, 32'd0);
    end
    check_all("count_end", 32'd10, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 23; i++) begin
      set_strobes(vecs[i].wr, vecs[i].data);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].rl, vecs[i].rh, vecs[i].cl, vecs[i].ch, vecs[i].ti);
    end
    set_strobes(4'b0000, 32'h0);

    // Bring mtime and mtimecmp to 0x1230, then count up to 0x1234 with timer_int high.
    set_strobes(4'b0101, 32'h0);
    step();
    set_strobes(4'b1010, 32'h1230);
    step();
    set_strobes(4'b0000, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check_all("pre_reset", 32'h1234, 32'h0, 32'h1230, 32'h0, 1'b1);

    // Reset pulse between edges, held across one edge with a write strobe active.
    #1;
    rst_n = 1'b0;
    set_strobes(4'b1000, 32'hDEAD);
    #2 check_all("async_rst", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #4 check_all("rst_hold", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #1;
    rst_n = 1'b1;
    set_strobes(4'b0000, 32'h0);
    step();
    check_all("post_rst", 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer (mtime/mtimecmp) sitting directly behind the SoC bus matrix. It consumes the four per-register active-low write strobes and the CPU write data the matrix decodes, and returns the four 32-bit register values the matrix muxes onto the CPU read bus. It also raises the machine timer interrupt to the core. Timer region reads and writes are single-cycle; the matrix reports ready for this region unconditionally.

## Interface
- `PRESCALE`, default 16: clock cycles per mtime increment when the prescaler is compiled in; legal range 2..65536.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `data_i` input 32: CPU write data, forwarded unchanged by the bus matrix.
- `wrtimel_n` input 1: active-low write strobe for mtime[31:0] (word 0x0000_E000).
- `wrtimeh_n` input 1: active-low write strobe for mtime[63:32] (word 0x0000_E004).
- `wrtimecmpl_n` input 1: active-low write strobe for mtimecmp[31:0] (word 0x0000_E008).
- `wrtimecmph_n` input 1: active-low write strobe for mtimecmp[63:32] (word 0x0000_E00C).
- `mtimerl_o` output 32: mtime[31:0].
- `mtimerh_o` output 32: mtime[63:32].
- `mtimecmpl_o` output 32: mtimecmp[31:0].
- `mtimecmph_o` output 32: mtimecmp[63:32].
- `timer_int` output 1: machine timer interrupt, level, active-high.

## Operation
- State: 64-bit `mtime`, 64-bit `mtimecmp`, prescaler counter (only when compiled in), registered `timer_int`.
- Read outputs are driven directly from the registers; no read side effects.
- Writes are level-sensitive. Every cycle a strobe is low, the selected half is loaded from `data_i` at the clock edge. A strobe held low for N cycles performs N identical writes.
- Multiple strobes low in one cycle: all selected halves load the same `data_i`.
- Increment: `mtime <= mtime + 1` on each tick, full 64-bit carry from low to high half. Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
- Write priority: in any cycle where `wrtimel_n` or `wrtimeh_n` is low, mtime does not increment. The unwritten half holds its value, and the written half takes `data_i` exactly. The prescaler counter clears to 0 in that cycle.
- mtimecmp writes never affect mtime or the prescaler.
- Interrupt: `timer_int <= (mtime >= mtimecmp)`, unsigned 64-bit compare of current register values, registered. It stays asserted while the condition holds and is cleared only by raising mtimecmp or lowering mtime; there is no sticky pending bit.
- Software updating mtimecmp writes high then low (or high to all-ones first). The block does not guard against the transient compare between the two writes.

## Timing
- Reset values: mtime = 0, mtimecmp = 0xFFFF_FFFF_FFFF_FFFF, prescaler = 0, `timer_int` = 0. So `mtimerl_o`/`mtimerh_o` = 0 and `mtimecmpl_o`/`mtimecmph_o` = 0xFFFF_FFFF.
- Reset asserted mid-operation immediately forces all of the above, regardless of strobes. The first increment after release happens at the first eligible edge (no prescaler) or the PRESCALE-th edge (prescaler).
- Write latency: a value written at edge k is visible on the read outputs after edge k.
- Interrupt latency: `timer_int` reflects the compare of the register values present before edge k, updated at edge k. It therefore lags a register change by one cycle.
- Tick without prescaler: every clock edge with no mtime write.
- Tick with prescaler: the edge where the prescaler counter equals PRESCALE-1; the counter then wraps to 0. Otherwise the counter increments.

## Configuration
- `MTIMER_PRESCALE_EN`
  - Defined: the prescaler counter (width clog2(PRESCALE)) is built, and mtime advances once per PRESCALE clocks.
  - Undefined: no prescaler logic is built, `PRESCALE` is ignored, and mtime advances every clock.
  - Reset values, write priority and interrupt behaviour are identical in both builds.

## Test plan
- **Reset and count:** release `rst_n`, no prescaler, run 10 cycles -> mtimerl_o = 10, mtimerh_o = 0, mtimecmp outputs 0xFFFF_FFFF, `timer_int` = 0 throughout.
- **Carry and wrap:** write low = 0xFFFF_FFFF and high = 0x0000_0001; after 1 tick -> low 0, high 2. Write high = 0xFFFF_FFFF and low = 0xFFFF_FFFF; after 1 tick -> both halves 0.
- **Write priority:** hold `wrtimel_n` low 3 cycles with `data_i` = 0x100 -> low = 0x100 during and immediately after (no increment). With the prescaler, the next increment lands exactly PRESCALE cycles after the strobe releases.
- **Compare:** mtime = 0, write cmph = 0 then cmpl = 5 -> `timer_int` rises exactly one cycle after mtime reaches 5. Write cmpl = 0xFFFF_FFFF -> `timer_int` falls one cycle after the write edge.
- **Simultaneous strobes:** all four strobes low one cycle with `data_i` = 0xA5A5_A5A5 -> all four outputs 0xA5A5_A5A5, and `timer_int` = 1 on the following cycle (mtime >= mtimecmp).
- **Async reset mid-run:** pulse `rst_n` low between edges while count = 0x1234 and `timer_int` = 1 -> outputs return to reset values before the next edge.
